// File: rtl/bgpu_rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package bgpu_rst_seq_pkg;

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StHold  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } rst_seq_state_e;

  // Width of a counter that can hold every value 0..n.
  function automatic int unsigned stage_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bgpu_rst_seq_sync.sv
// Two-flop synchroniser bank for asynchronous status inputs.
module bgpu_rst_seq_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bgpu_rst_sequencer.sv
// Ordered reset release for NumDomains domains with readiness debounce and collapse handling.
// Optional stage timeout / FAULT state is enabled by defining BGPU_RST_SEQ_TIMEOUT_EN.
module bgpu_rst_sequencer
  import bgpu_rst_seq_pkg::*;
#(
  parameter int unsigned NumDomains    = 3,
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned TimeoutCycles = 1048576
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_rst_i,
  input  logic [NumDomains-1:0]               ready_i,
  output logic [NumDomains-1:0]               rst_no,
  output logic [stage_width(NumDomains)-1:0]  stage_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                timeout_o
);

  localparam int unsigned SW = stage_width(NumDomains);
  localparam int unsigned HW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HW-1:0] HoldLast  = HW'(HoldCycles - 1);
  localparam logic [SW-1:0] LastStage = SW'(NumDomains - 1);

  logic [NumDomains-1:0] rdy;
  logic [(1<<SW)-1:0]    rdy_ext;
  logic                  rdy_cur;

  rst_seq_state_e        state_q, state_d;
  logic [SW-1:0]         stg_q, stg_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [NumDomains-1:0] rst_no_q, rst_no_d;
  logic                  busy_q, done_q;

  logic                  coll;
  logic [SW-1:0]         coll_idx;

  bgpu_rst_seq_sync #(
    .Width(NumDomains)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ready_i),
    .q_o  (rdy)
  );

  // Pad so indexing by stg_q is always in range, even at stg == NumDomains.
  always_comb begin
    rdy_ext = '0;
    rdy_ext[NumDomains-1:0] = rdy;
  end
  assign rdy_cur = rdy_ext[stg_q];

  // Lowest released domain that lost readiness; descending loop so the lowest index wins.
  always_comb begin
    coll     = 1'b0;
    coll_idx = '0;
    for (int k = NumDomains - 1; k >= 0; k--) begin
      if (rst_no_q[k] && !rdy[k]) begin
        coll     = 1'b1;
        coll_idx = SW'(k);
      end
    end
  end

`ifdef BGPU_RST_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TcntLast = TW'(TimeoutCycles - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q;
`endif

  always_comb begin
    state_d  = state_q;
    stg_d    = stg_q;
    hcnt_d   = hcnt_q;
    rst_no_d = rst_no_q;
`ifdef BGPU_RST_SEQ_TIMEOUT_EN
    tcnt_d   = tcnt_q;
`endif
    if (req_rst_i) begin
      state_d  = StWait;
      stg_d    = '0;
      hcnt_d   = '0;
      rst_no_d = '0;
`ifdef BGPU_RST_SEQ_TIMEOUT_EN
      tcnt_d   = '0;
`endif
    end else if (coll) begin
      state_d = StWait;
      stg_d   = coll_idx;
      hcnt_d  = '0;
      for (int k = 0; k < NumDomains; k++) begin
        if (SW'(k) >= coll_idx) rst_no_d[k] = 1'b0;
      end
`ifdef BGPU_RST_SEQ_TIMEOUT_EN
      tcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        StWait: begin
          if (rdy_cur) begin
            state_d = StHold;
            hcnt_d  = '0;
          end
        end
        StHold: begin
          if (!rdy_cur) begin
            state_d = StWait;
            hcnt_d  = '0;
          end else if (hcnt_q == HoldLast) begin
            for (int k = 0; k < NumDomains; k++) begin
              if (SW'(k) == stg_q) rst_no_d[k] = 1'b1;
            end
            stg_d   = stg_q + 1'b1;
            hcnt_d  = '0;
            state_d = (stg_q == LastStage) ? StRun : StWait;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef BGPU_RST_SEQ_TIMEOUT_EN
      // Timeout overrides any progress made by the same cycle.
      if (state_q == StWait || state_q == StHold) begin
        if (tcnt_q == TcntLast) begin
          state_d  = StFault;
          stg_d    = stg_q;
          hcnt_d   = '0;
          rst_no_d = '0;
        end else if (stg_d != stg_q) begin
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StWait;
      stg_q    <= '0;
      hcnt_q   <= '0;
      rst_no_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stg_q    <= stg_d;
      hcnt_q   <= hcnt_d;
      rst_no_q <= rst_no_d;
      busy_q   <= (state_d == StWait) || (state_d == StHold);
      done_q   <= (state_d == StRun);
    end
  end

`ifdef BGPU_RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= (state_d == StFault);
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_o = 1'b0;
`endif

  assign rst_no  = rst_no_q;
  assign stage_o = stg_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
